// File: rtl/mem_pkg.sv
// Shared types and constants for the word-addressed memory responder.
// Holds the FSM state encoding and the request mode constants.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (master) and the memory responder (slave).
// One request in flight at a time; completion is a single-cycle strobe.
interface mem_responder_if;
  import mem_pkg::*;

  logic              request_enable;
  logic              req_mode;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              response_enable;
  logic [DATA_W-1:0] resp_data;
  logic              busy;
  logic              protocol_error;

  modport master (
    output request_enable, req_mode, req_addr, req_wdata, req_wstrb,
    input  response_enable, resp_data, busy, protocol_error
  );

  modport slave (
    input  request_enable, req_mode, req_addr, req_wdata, req_wstrb,
    output response_enable, resp_data, busy, protocol_error
  );

endinterface

// File: rtl/mem_bram_bytewise.sv
// Simple dual-port word memory: registered read port, byte-lane write port.
// Contents are never reset so the array maps onto block RAM.
module mem_bram_bytewise
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [STRB_W-1:0]     wr_be
);

  logic [DATA_W-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request, answers after LATENCY cycles.
// Writes commit the cycle after accept; reads are launched at accept so LATENCY=1 works.
module mem_responder
  import mem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam logic [32:0] SPAN     = 33'd4 << ADDR_WIDTH;
  localparam logic [3:0]  CNT_LAST = 4'(LATENCY - 1);

  // Compare in 33 bits so a window ending at 2^32 does not wrap.
  function automatic logic in_range(input logic [31:0] addr);
    logic [32:0] a;
    logic [32:0] lo;
    a  = {1'b0, addr};
    lo = {1'b0, BASE_ADDR};
    return (a >= lo) && (a < lo + SPAN);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return ADDR_WIDTH'(off >> 2);
  endfunction

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  accept;
  logic                  vld_p0;
  logic                  rd_ok_p0;
  logic                  perr;
  logic                  mode_p0;
  logic                  inrange_p0;
  logic [ADDR_WIDTH-1:0] widx_p0;
  logic [DATA_W-1:0]     wdata_p0;
  logic [STRB_W-1:0]     wstrb_p0;
  logic [DATA_W-1:0]     rd_word;
  logic [DATA_W-1:0]     resp_q;
  logic [DATA_W-1:0]     resp_nxt;
  logic                  rd_en;
  logic                  wr_en;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.request_enable) begin
          accept    = 1'b1;
          cnt_nxt   = 4'd1;
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == CNT_LAST) state_nxt = RESP;
        else                 cnt_nxt   = cnt + 4'd1;
      end
      RESP: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Stage p0: request captured at accept, control side resettable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      vld_p0   <= 1'b0;
      rd_ok_p0 <= 1'b0;
      resp_q   <= '0;
      perr     <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      vld_p0 <= accept;
      if (accept) rd_ok_p0 <= (bus.req_mode == REQ_READ) && in_range(bus.req_addr);
      if (state == RESP) resp_q <= resp_nxt;
      if (bus.request_enable && (state != IDLE)) perr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mode_p0    <= bus.req_mode;
      inrange_p0 <= in_range(bus.req_addr);
      widx_p0    <= word_index(bus.req_addr);
      wdata_p0   <= bus.req_wdata;
      wstrb_p0   <= bus.req_wstrb;
    end
  end

  // Stage p1: write commits from the captured request; read data lands from the accept-time read.
  assign rd_en = accept && (bus.req_mode == REQ_READ) && in_range(bus.req_addr);
  assign wr_en = vld_p0 && (mode_p0 == REQ_WRITE) && inrange_p0;

  mem_bram_bytewise #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bram (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (word_index(bus.req_addr)),
    .rd_data (rd_word),
    .wr_en   (wr_en),
    .wr_addr (widx_p0),
    .wr_data (wdata_p0),
    .wr_be   (wstrb_p0)
  );

  // Live value during the response cycle, latched copy held afterwards.
  assign resp_nxt            = rd_ok_p0 ? rd_word : '0;
  assign bus.resp_data       = (state == RESP) ? resp_nxt : resp_q;
  assign bus.response_enable = (state == RESP);
  assign bus.busy            = (state != IDLE);
  assign bus.protocol_error  = perr;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=2 instance for function, LATENCY=1 for spacing.
// Inputs change 1 time unit after posedge; outputs are sampled at the same point.
module tb_mem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_responder_if bus ();
  mem_responder_if bus1 ();

  mem_responder #(.ADDR_WIDTH(14), .BASE_ADDR(32'h0), .LATENCY(2)) dut (
    .clk (clk), .rst (rst), .bus (bus.slave)
  );

  mem_responder #(.ADDR_WIDTH(14), .BASE_ADDR(32'h0), .LATENCY(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic mode, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] st);
    bus.request_enable = en;
    bus.req_mode       = mode;
    bus.req_addr       = addr;
    bus.req_wdata      = wd;
    bus.req_wstrb      = st;
  endtask

  // One transaction on the LATENCY=2 instance: latency, data and single-cycle pulse.
  task automatic xact(input logic mode, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] exp, input string tag);
    int lat;
    drive(1'b1, mode, addr, wd, st);
    tick();
    drive(1'b0, REQ_READ, 32'h0, 32'h0, 4'h0);
    lat = 1;
    while (!bus.response_enable && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check({tag, "_data"}, bus.resp_data, exp);
    tick();
    check({tag, "_pulse_end"}, {31'b0, bus.response_enable}, 32'd0);
    check({tag, "_held"}, bus.resp_data, exp);
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    drive(1'b0, REQ_READ, 32'h0, 32'h0, 4'h0);
    bus1.request_enable = 1'b0;
    bus1.req_mode       = REQ_READ;
    bus1.req_addr       = 32'h0;
    bus1.req_wdata      = 32'h0;
    bus1.req_wstrb      = 4'h0;
    tick();
    tick();
    check("rst_resp_en", {31'b0, bus.response_enable}, 32'd0);
    check("rst_busy",    {31'b0, bus.busy},            32'd0);
    check("rst_perr",    {31'b0, bus.protocol_error},  32'd0);
    check("rst_data",    bus.resp_data,                32'h0);
    rst = 1'b0;
    tick();

    // Full-word write, busy visible the cycle after accept, then read back.
    drive(1'b1, REQ_WRITE, 32'h100, 32'hDEAD_BEEF, 4'hF);
    tick();
    drive(1'b0, REQ_READ, 32'h0, 32'h0, 4'h0);
    check("wr_busy_t1", {31'b0, bus.busy},            32'd1);
    check("wr_resp_t1", {31'b0, bus.response_enable}, 32'd0);
    tick();
    check("wr_resp_t2", {31'b0, bus.response_enable}, 32'd1);
    check("wr_data_t2", bus.resp_data,                32'h0);
    tick();
    check("wr_idle_busy", {31'b0, bus.busy}, 32'd0);
    xact(REQ_READ,  32'h100, 32'h0,         4'h0,    32'hDEAD_BEEF, "rd_full");

    // Byte strobes.
    xact(REQ_WRITE, 32'h100, 32'h0000_00AA, 4'b0001, 32'h0,         "wr_b0");
    xact(REQ_READ,  32'h100, 32'h0,         4'h0,    32'hDEAD_BEAA, "rd_b0");
    xact(REQ_WRITE, 32'h100, 32'h1122_3344, 4'b0000, 32'h0,         "wr_none");
    xact(REQ_READ,  32'h101, 32'h0,         4'h0,    32'hDEAD_BEAA, "rd_none");
    xact(REQ_WRITE, 32'h104, 32'h0,         4'hF,    32'h0,         "wr_clr");
    xact(REQ_WRITE, 32'h104, 32'hAABB_CCDD, 4'b1010, 32'h0,         "wr_b13");
    xact(REQ_READ,  32'h104, 32'h0,         4'h0,    32'hAA00_CC00, "rd_b13");

    // Range boundaries: last word in range, first word out of range.
    xact(REQ_WRITE, 32'hFFFC,     32'h5A5A_0FF0, 4'hF, 32'h0,         "wr_last");
    xact(REQ_READ,  32'hFFFC,     32'h0,         4'h0, 32'h5A5A_0FF0, "rd_last");
    xact(REQ_WRITE, 32'h0,        32'h1234_5678, 4'hF, 32'h0,         "wr_w0");
    xact(REQ_WRITE, 32'h0001_0000, 32'hFFFF_FFFF, 4'hF, 32'h0,        "wr_oor");
    xact(REQ_READ,  32'h0,        32'h0,         4'h0, 32'h1234_5678, "rd_w0");
    xact(REQ_READ,  32'h0001_0000, 32'h0,        4'h0, 32'h0,         "rd_oor");
    xact(REQ_READ,  32'hFFFF_FFFC, 32'h0,        4'h0, 32'h0,         "rd_top");
    xact(REQ_READ,  32'h100,      32'h0,         4'h0, 32'hDEAD_BEAA, "rd_after_oor");

    // Second request while busy is dropped and flagged.
    check("perr_before", {31'b0, bus.protocol_error}, 32'd0);
    drive(1'b1, REQ_READ, 32'h100, 32'h0, 4'h0);
    tick();
    drive(1'b1, REQ_READ, 32'h104, 32'h0, 4'h0);
    check("ovl_busy_t1", {31'b0, bus.busy}, 32'd1);
    tick();
    drive(1'b0, REQ_READ, 32'h0, 32'h0, 4'h0);
    check("ovl_resp_t2", {31'b0, bus.response_enable}, 32'd1);
    check("ovl_data_t2", bus.resp_data,                32'hDEAD_BEAA);
    check("ovl_perr_t2", {31'b0, bus.protocol_error},  32'd1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.response_enable) pulses++;
    end
    check("ovl_extra_pulses", 32'(pulses), 32'd0);
    check("ovl_perr_sticky", {31'b0, bus.protocol_error}, 32'd1);

    // Reset in the cycle after a read is accepted.
    drive(1'b1, REQ_READ, 32'h100, 32'h0, 4'h0);
    tick();
    drive(1'b0, REQ_READ, 32'h0, 32'h0, 4'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_resp", {31'b0, bus.response_enable}, 32'd0);
    check("mrst_busy", {31'b0, bus.busy},            32'd0);
    check("mrst_perr", {31'b0, bus.protocol_error},  32'd0);
    check("mrst_data", bus.resp_data,                32'h0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.response_enable) pulses++;
    end
    check("mrst_pulses", 32'(pulses), 32'd0);
    xact(REQ_READ, 32'h100, 32'h0, 4'h0, 32'hDEAD_BEAA, "rd_post_rst");

    // LATENCY=1 instance: write, then reads at T and T+2.
    bus1.request_enable = 1'b1;
    bus1.req_mode       = REQ_WRITE;
    bus1.req_addr       = 32'h8;
    bus1.req_wdata      = 32'hCAFE_F00D;
    bus1.req_wstrb      = 4'hF;
    tick();
    bus1.request_enable = 1'b0;
    check("l1_wr_resp", {31'b0, bus1.response_enable}, 32'd1);
    tick();
    check("l1_wr_idle", {31'b0, bus1.busy}, 32'd0);
    bus1.request_enable = 1'b1;
    bus1.req_mode       = REQ_READ;
    bus1.req_addr       = 32'h8;
    tick();
    bus1.request_enable = 1'b0;
    check("l1_rd1_resp", {31'b0, bus1.response_enable}, 32'd1);
    check("l1_rd1_busy", {31'b0, bus1.busy},            32'd1);
    check("l1_rd1_data", bus1.resp_data,                32'hCAFE_F00D);
    tick();
    check("l1_gap_resp", {31'b0, bus1.response_enable}, 32'd0);
    check("l1_gap_busy", {31'b0, bus1.busy},            32'd0);
    check("l1_gap_data", bus1.resp_data,                32'hCAFE_F00D);
    bus1.request_enable = 1'b1;
    bus1.req_addr       = 32'h0001_0000;
    tick();
    bus1.request_enable = 1'b0;
    check("l1_rd2_resp", {31'b0, bus1.response_enable}, 32'd1);
    check("l1_rd2_busy", {31'b0, bus1.busy},            32'd1);
    check("l1_rd2_data", bus1.resp_data,                32'h0);
    tick();
    check("l1_end_resp", {31'b0, bus1.response_enable}, 32'd0);
    check("l1_end_busy", {31'b0, bus1.busy},            32'd0);
    check("l1_perr",     {31'b0, bus1.protocol_error},  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, meaning log2 of word capacity (16384 words, 64 KiB).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 2, meaning cycles from request accept to response pulse; legal range 1..15.
REQ-004 SHALL have port clk  in  1  the single clock; all logic rises on its posedge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port request_enable  in  1  single-cycle request strobe from the initiator.
REQ-007 SHALL have port req_mode  in  1  0 = read, 1 = write.
REQ-008 SHALL have port req_addr  in  32  byte address; bits [1:0] ignored.
REQ-009 SHALL have port req_wdata  in  32  write data.
REQ-010 SHALL have port req_wstrb  in  4  byte write enables; bit i covers wdata[8i+7:8i].
REQ-011 SHALL have port response_enable  out  1  single-cycle completion strobe.
REQ-012 SHALL have port resp_data  out  32  read data; valid in the response_enable cycle.
REQ-013 SHALL have port busy  out  1  high while a request is outstanding.
REQ-014 SHALL have port protocol_error  out  1  sticky flag for a request dropped while busy.

Function
REQ-015 SHALL use FSM states IDLE, WAIT, RESP; IDLE->WAIT on an accepted request; WAIT->RESP once the counter reaches LATENCY-1; RESP->IDLE unconditionally.
REQ-016 SHALL skip WAIT (IDLE->RESP directly) when LATENCY = 1.
REQ-017 SHALL accept a request only when request_enable = 1 in IDLE; the accept cycle is T.
REQ-018 SHALL register req_mode, word index, wdata, wstrb and an in-range flag at T.
REQ-019 SHALL treat the request as in range iff BASE_ADDR <= req_addr < BASE_ADDR + 4*2^ADDR_WIDTH, using 33-bit compare arithmetic (no wrap at 2^32).
REQ-020 SHALL perform an in-range write at cycle T+1, updating only bytes with wstrb set; wstrb = 0 updates nothing.
REQ-021 SHALL read the array at T+1 for an in-range read and hold the word until the response.
REQ-022 SHALL assert response_enable for exactly one cycle, at T+LATENCY, for every accepted request, including out-of-range ones.
REQ-023 SHALL drive resp_data to the read word for in-range reads, to 32'h0 for out-of-range reads and all writes, and hold it until the next response.
REQ-024 SHALL drop out-of-range writes silently.
REQ-025 SHALL assert busy from T+1 through the response cycle inclusive; busy = 0 in IDLE.
REQ-026 SHALL ignore request_enable when not in IDLE, including in the RESP cycle, and set protocol_error, which clears only on rst.
REQ-027 SHALL accept back-to-back requests: a request in the cycle after RESP is accepted, giving a minimum spacing of LATENCY+1 cycles.
REQ-028 SHALL return newly written data on a read issued after a write's response (serialized, no hazard).

Reset
REQ-029 SHALL, on rst = 1 at a clock edge, set state IDLE, counter 0, response_enable 0, resp_data 32'h0, busy 0 and protocol_error 0.
REQ-030 SHALL abandon any outstanding request on mid-operation reset, with no response pulse; a write that already committed at T+1 stays committed.
REQ-031 SHALL NOT clear array contents on reset.

Structure
REQ-032 SHALL place the state enum (IDLE/WAIT/RESP) and the REQ_READ/REQ_WRITE constants in shared package mem_pkg.
REQ-033 SHALL put the storage in one sub-module, mem_bram_bytewise: synchronous read, 4 byte-enable write lanes, inferable as block RAM.
REQ-034 SHALL keep the FSM, counter, range check and response registers in mem_responder.

Verification
REQ-035 Write 0xDEADBEEF, wstrb 4'hF, to addr 0x100 at cycle T, then read 0x100 -> response_enable pulses at T+2 and at the read's T+2, with read resp_data = 0xDEADBEEF.
REQ-036 Write 0x000000AA, wstrb 4'b0001, to 0x100 over 0xDEADBEEF, then read -> 0xDEADBEAA.
REQ-037 Read 0x0001_0000 (out of range, defaults) -> one response pulse, resp_data = 0x0, array unchanged.
REQ-038 Second request_enable at T+1 while busy -> ignored; protocol_error = 1 and stays set; exactly one response.
REQ-039 rst asserted at T+1 of a read -> no response_enable; all outputs at reset values; next request accepted normally.
REQ-040 With LATENCY = 1, back-to-back reads at T and T+2 -> responses at T+1 and T+3, busy high only in those cycles.
